axi_stream_header_arbiter: RTL and testbench
============================================

// Module: axi_stream_header_arbiter
// PURPOSE
//  - Round-robin arbiter sharing the single header-insert port of axi_stream_insert_header among NUM_SRC header requesters.
//  - Grants one requester per packet, captures its header, presents it on the insert port, then holds the grant until the packet's last output beat.
//  - Sits directly in front of the insert block; snoops its output-stream handshake to detect end-of-packet (EOP).
// PARAMETERS
//  DATA_WD      32                        header/data width in bits
//  DATA_BYTE_WD DATA_WD/8                 bytes per beat
//  BYTE_CNT_WD  $clog2(DATA_BYTE_WD)      width of byte_insert_cnt
//  NUM_SRC      4                         number of header requesters, 2..16
//  SRC_WD       (NUM_SRC>1)?$clog2(NUM_SRC):1   grant index width
//  TIMEOUT_CYC  1024                      EOP watchdog limit, only used with HDR_TIMEOUT_EN
// PORTS
//  clk             in   1                       clock, rising edge
//  rst             in   1                       synchronous active-high reset
//  req_valid       in   NUM_SRC                 per-source header valid
//  req_data        in   NUM_SRC*DATA_WD         headers, source i at [i*DATA_WD +: DATA_WD]
//  req_keep        in   NUM_SRC*DATA_BYTE_WD    per-source keep
//  req_cnt         in   NUM_SRC*BYTE_CNT_WD     per-source byte_insert_cnt
//  req_ready       out  NUM_SRC                 one-hot capture strobe to winning source
//  valid_insert    out  1                       to insert block
//  data_insert     out  DATA_WD                 to insert block
//  keep_insert     out  DATA_BYTE_WD            to insert block
//  byte_insert_cnt out  BYTE_CNT_WD             to insert block
//  ready_insert    in   1                       from insert block
//  valid_out       in   1                       snooped insert-block output valid
//  ready_out       in   1                       snooped downstream ready
//  last_out        in   1                       snooped insert-block output last
//  grant_id        out  SRC_WD                  index of current/last granted source
//  busy            out  1                       high in OFFER or WAIT_EOP
//  timeout         out  1                       one-cycle watchdog pulse; port exists only with HDR_TIMEOUT_EN
// BEHAVIOUR
//  - Reset: state=IDLE; valid_insert, req_ready, busy, timeout=0; data/keep/cnt regs=0; grant_id=0; rr_ptr=NUM_SRC-1, so source 0 wins first.
//  - FSM: IDLE -> OFFER -> WAIT_EOP -> IDLE.
//  - IDLE: search req_valid starting at rr_ptr+1 modulo NUM_SRC. The first set bit wins.
//      - Winner's req_ready is high combinationally in the same cycle; that cycle is the capture handshake.
//      - Capture req_data/keep/cnt slice into output regs; grant_id=rr_ptr=winner; next state OFFER.
//      - No request: stay in IDLE with req_ready=0.
//  - OFFER: valid_insert=1. data/keep/cnt are registered and held stable until ready_insert. req_ready=0 for all sources.
//      - valid_insert & ready_insert: next state WAIT_EOP, valid_insert drops the next cycle.
//  - WAIT_EOP: wait for valid_out & ready_out & last_out, then go to IDLE.
//      - A new grant is possible in the first IDLE cycle after EOP.
//  - Latency: req_valid to valid_insert is 1 cycle. Minimum spacing between grants is 3 cycles.
//  - EOP events seen in IDLE or OFFER are ignored. In OFFER, an EOP coincident with ready_insert is also ignored; the FSM still enters WAIT_EOP.
//  - Requests dropped by a source before capture are harmless: arbitration uses only the current cycle.
//  - busy = (state != IDLE). Reset asserted in any state returns to the reset values on the next edge.
//  - Fairness: a continuously requesting source waits at most NUM_SRC-1 grants.
// CONFIGURATION
//  - HDR_TIMEOUT_EN defined:
//      - 16-bit counter clears on entering WAIT_EOP and increments each cycle in WAIT_EOP.
//      - At count == TIMEOUT_CYC-1 with no EOP: go to IDLE and pulse timeout for 1 cycle.
//      - EOP in the same cycle as the limit takes priority: no timeout pulse.
//  - HDR_TIMEOUT_EN undefined: no counter, no timeout port; WAIT_EOP waits indefinitely.
// TESTING
//  1. Reset: rst=1 for 2 clks with req_valid=4'hF -> all outputs 0, req_ready=0. After release, source 0 granted (grant_id=0, req_ready=4'b0001).
//  2. Single header: src2 requests data=32'hA5A5_0001, keep=4'hF, cnt=2, ready_insert=0 for 3 clks -> valid_insert high, data/keep/cnt stable for 3 clks.
//     Then ready_insert=1 -> WAIT_EOP. last_out beat with valid_out=ready_out=1 -> IDLE, busy=0.
//  3. Round-robin: req_valid=4'hF held over 4 packets -> grant order 0,1,2,3, then 0 again. Each req_ready pulse is exactly 1 cycle.
//  4. Backpressure at EOP: last_out=1, valid_out=1, ready_out=0 for 5 clks -> stays in WAIT_EOP. EOP takes effect only on the cycle ready_out=1.
//  5. Mid-operation reset: rst in WAIT_EOP and in OFFER -> valid_insert=0, busy=0 next clk; src0 wins the first re-grant.
//  6. HDR_TIMEOUT_EN, TIMEOUT_CYC=8: no EOP after header accept -> timeout pulse exactly 8 clks after WAIT_EOP entry, then IDLE.
//     EOP on the 8th clk -> no pulse.

Source files
------------

// File: rtl/axi_stream_header_arbiter.sv
// Round-robin owner of the single header-insert port of axi_stream_insert_header.
// Define HDR_TIMEOUT_EN to add the end-of-packet watchdog and the timeout output.
module axi_stream_header_arbiter #(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD),
  parameter int NUM_SRC      = 4,
  parameter int SRC_WD       = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1,
  parameter int TIMEOUT_CYC  = 1024
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_SRC-1:0]              req_valid,
  input  logic [NUM_SRC*DATA_WD-1:0]      req_data,
  input  logic [NUM_SRC*DATA_BYTE_WD-1:0] req_keep,
  input  logic [NUM_SRC*BYTE_CNT_WD-1:0]  req_cnt,
  output logic [NUM_SRC-1:0]              req_ready,
  output logic                            valid_insert,
  output logic [DATA_WD-1:0]              data_insert,
  output logic [DATA_BYTE_WD-1:0]         keep_insert,
  output logic [BYTE_CNT_WD-1:0]          byte_insert_cnt,
  input  logic                            ready_insert,
  input  logic                            valid_out,
  input  logic                            ready_out,
  input  logic                            last_out,
  output logic [SRC_WD-1:0]               grant_id,
`ifdef HDR_TIMEOUT_EN
  output logic                            timeout,
`endif
  output logic                            busy
);

  typedef enum logic [1:0] {IDLE, OFFER, WAIT_EOP} state_e;

  state_e                  state_q, state_d;
  logic [DATA_WD-1:0]      data_q, data_d;
  logic [DATA_BYTE_WD-1:0] keep_q, keep_d;
  logic [BYTE_CNT_WD-1:0]  cnt_q, cnt_d;
  logic [SRC_WD-1:0]       grant_q, grant_d;
  logic [SRC_WD-1:0]       rr_q, rr_d;
  logic                    found;
  logic [SRC_WD-1:0]       winner;
  logic                    eop;
`ifdef HDR_TIMEOUT_EN
  logic [15:0]             timer_q, timer_d;
  logic                    timeout_q, timeout_d;
`endif

  if (NUM_SRC < 2 || NUM_SRC > 16 || TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65536) begin : g_bad_param
    $error("axi_stream_header_arbiter: NUM_SRC or TIMEOUT_CYC out of range");
  end

  assign eop             = valid_out & ready_out & last_out;
  assign valid_insert    = (state_q == OFFER);
  assign busy            = (state_q != IDLE);
  assign data_insert     = data_q;
  assign keep_insert     = keep_q;
  assign byte_insert_cnt = cnt_q;
  assign grant_id        = grant_q;
`ifdef HDR_TIMEOUT_EN
  assign timeout         = timeout_q;
`endif

  // Search starts one past the last winner, so the previous owner is checked last.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      if (!found && req_valid[(int'(rr_q) + k) % NUM_SRC]) begin
        found  = 1'b1;
        winner = SRC_WD'((int'(rr_q) + k) % NUM_SRC);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    keep_d    = keep_q;
    cnt_d     = cnt_q;
    grant_d   = grant_q;
    rr_d      = rr_q;
    req_ready = '0;
`ifdef HDR_TIMEOUT_EN
    timer_d   = timer_q;
    timeout_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (found) begin
          req_ready[winner] = 1'b1;
          data_d  = req_data[winner*DATA_WD +: DATA_WD];
          keep_d  = req_keep[winner*DATA_BYTE_WD +: DATA_BYTE_WD];
          cnt_d   = req_cnt[winner*BYTE_CNT_WD +: BYTE_CNT_WD];
          grant_d = winner;
          rr_d    = winner;
          state_d = OFFER;
        end
      end
      OFFER: begin
        if (ready_insert) begin
          state_d = WAIT_EOP;
`ifdef HDR_TIMEOUT_EN
          timer_d = '0;
`endif
        end
      end
      WAIT_EOP: begin
        if (eop) begin
          state_d = IDLE;
        end
`ifdef HDR_TIMEOUT_EN
        else if (timer_q == 16'(TIMEOUT_CYC - 1)) begin
          state_d   = IDLE;
          timeout_d = 1'b1;
        end else begin
          timer_d = timer_q + 16'd1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
    // The capture strobe must not fire while the arbiter is being reset.
    if (rst) begin
      req_ready = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      keep_q  <= '0;
      cnt_q   <= '0;
      grant_q <= '0;
      rr_q    <= SRC_WD'(NUM_SRC - 1);
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      keep_q  <= keep_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
    end
  end

`ifdef HDR_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      timer_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      timer_q   <= timer_d;
      timeout_q <= timeout_d;
    end
  end
`endif

endmodule

// File: tb/tb_axi_stream_header_arbiter.sv
// Self-checking bench for axi_stream_header_arbiter: directed scenarios with literal
// expectations, then randomized traffic against a transaction-level model.
`timescale 1ns/1ps
module tb_axi_stream_header_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int BW = DW / 8;
  localparam int CW = 2;
  localparam int SW = 2;
  localparam int TO = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data;
  logic [N*BW-1:0] req_keep;
  logic [N*CW-1:0] req_cnt;
  logic [N-1:0]    req_ready;
  logic            valid_insert;
  logic [DW-1:0]   data_insert;
  logic [BW-1:0]   keep_insert;
  logic [CW-1:0]   byte_insert_cnt;
  logic            ready_insert;
  logic            valid_out;
  logic            ready_out;
  logic            last_out;
  logic [SW-1:0]   grant_id;
  logic            busy;
`ifdef HDR_TIMEOUT_EN
  logic            timeout;
`endif

  int errors = 0;
  int checks = 0;
  bit checkEn = 1'b0;

  always #5 clk = ~clk;

  axi_stream_header_arbiter #(.DATA_WD(DW), .NUM_SRC(N), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data), .req_keep(req_keep), .req_cnt(req_cnt),
    .req_ready(req_ready),
    .valid_insert(valid_insert), .data_insert(data_insert), .keep_insert(keep_insert),
    .byte_insert_cnt(byte_insert_cnt), .ready_insert(ready_insert),
    .valid_out(valid_out), .ready_out(ready_out), .last_out(last_out),
    .grant_id(grant_id),
`ifdef HDR_TIMEOUT_EN
    .timeout(timeout),
`endif
    .busy(busy)
  );

  // Packet-level view: which source owns the port, whether its header is still
  // waiting to be accepted, or whether its packet body is still streaming.
  int            mPtr, mGrant, mTimer, mWin;
  bit            mHeaderPending, mPacketOpen, mTimeout;
  logic [DW-1:0] mData;
  logic [BW-1:0] mKeep;
  logic [CW-1:0] mCnt;

  function automatic int pickSource(input logic [N-1:0] rv, input int ptr);
    for (int k = 1; k <= N; k++) begin
      if (rv[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      mPtr = N - 1; mGrant = 0; mTimer = 0; mTimeout = 1'b0;
      mHeaderPending = 1'b0; mPacketOpen = 1'b0;
      mData = '0; mKeep = '0; mCnt = '0;
    end else begin
      mTimeout = 1'b0;
      if (mHeaderPending) begin
        if (ready_insert) begin
          mHeaderPending = 1'b0; mPacketOpen = 1'b1; mTimer = 0;
        end
      end else if (mPacketOpen) begin
        if (valid_out && ready_out && last_out) mPacketOpen = 1'b0;
`ifdef HDR_TIMEOUT_EN
        else if (mTimer == TO - 1) begin
          mPacketOpen = 1'b0; mTimeout = 1'b1;
        end else mTimer++;
`endif
      end else begin
        mWin = pickSource(req_valid, mPtr);
        if (mWin >= 0) begin
          mPtr = mWin; mGrant = mWin; mHeaderPending = 1'b1;
          mData = req_data[mWin*DW +: DW];
          mKeep = req_keep[mWin*BW +: BW];
          mCnt  = req_cnt[mWin*CW +: CW];
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [N-1:0] expRdy;
    int w;
    if (checkEn) begin
      expRdy = '0;
      if (!rst && !mHeaderPending && !mPacketOpen) begin
        w = pickSource(req_valid, mPtr);
        if (w >= 0) expRdy[w] = 1'b1;
      end
      checkOutput("req_ready", req_ready, expRdy);
      checkOutput("valid_insert", valid_insert, mHeaderPending);
      checkOutput("busy", busy, mHeaderPending | mPacketOpen);
      checkOutput("grant_id", grant_id, mGrant);
      checkOutput("data_insert", data_insert, mData);
      checkOutput("keep_insert", keep_insert, mKeep);
      checkOutput("byte_insert_cnt", byte_insert_cnt, mCnt);
`ifdef HDR_TIMEOUT_EN
      checkOutput("timeout", timeout, mTimeout);
`endif
    end
  end

  task automatic applyStimulus(input logic r, input logic [N-1:0] rv, input logic ri,
                               input logic vo, input logic ro, input logic lo);
    rst = r; req_valid = rv; ready_insert = ri;
    valid_out = vo; ready_out = ro; last_out = lo;
    for (int i = 0; i < N; i++) begin
      req_data[i*DW +: DW] = $urandom;
      req_keep[i*BW +: BW] = BW'($urandom);
      req_cnt[i*CW +: CW]  = CW'($urandom);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    applyStimulus(1, 4'hF, 0, 0, 0, 0);
    tick();
    checkEn = 1'b1;
    tick();
    #1;
    checkOutput("rst_req_ready", req_ready, 0);
    checkOutput("rst_valid_insert", valid_insert, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_grant_id", grant_id, 0);
    checkOutput("rst_data", data_insert, 0);
`ifdef HDR_TIMEOUT_EN
    checkOutput("rst_timeout", timeout, 0);
`endif

    for (int p = 0; p < 5; p++) begin
      applyStimulus(0, 4'hF, 0, 0, 0, 0);
      #1;
      checkOutput("rr_req_ready", req_ready, 4'b0001 << (p % 4));
      tick(); #1;
      checkOutput("rr_grant_id", grant_id, p % 4);
      checkOutput("rr_ready_pulse", req_ready, 0);
      checkOutput("rr_valid_insert", valid_insert, 1);
      applyStimulus(0, 4'hF, 1, 0, 0, 0);
      tick(); #1;
      checkOutput("rr_wait_busy", busy, 1);
      checkOutput("rr_wait_valid", valid_insert, 0);
      applyStimulus(0, 4'hF, 0, 1, 1, 1);
      tick();
    end

    applyStimulus(0, 4'b0100, 0, 0, 0, 0);
    req_data[2*DW +: DW] = 32'hA5A5_0001;
    req_keep[2*BW +: BW] = 4'hF;
    req_cnt[2*CW +: CW]  = 2'd2;
    #1;
    checkOutput("single_req_ready", req_ready, 4'b0100);
    tick();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 4'h0, 0, 0, 0, 0);
      #1;
      checkOutput("single_valid", valid_insert, 1);
      checkOutput("single_data", data_insert, 32'hA5A5_0001);
      checkOutput("single_keep", keep_insert, 4'hF);
      checkOutput("single_cnt", byte_insert_cnt, 2);
      checkOutput("single_grant", grant_id, 2);
      tick();
    end
    applyStimulus(0, 4'h0, 1, 0, 0, 0);
    tick(); #1;
    checkOutput("single_wait_busy", busy, 1);
    checkOutput("single_wait_valid", valid_insert, 0);

    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 4'h0, 0, 1, 0, 1);
      tick(); #1;
      checkOutput("bp_eop_held", busy, 1);
    end
    applyStimulus(0, 4'h0, 0, 1, 1, 1);
    tick(); #1;
    checkOutput("bp_eop_taken", busy, 0);

    applyStimulus(0, 4'hF, 0, 0, 0, 0);
    tick();
    applyStimulus(0, 4'hF, 1, 0, 0, 0);
    tick();
    applyStimulus(1, 4'hF, 0, 0, 0, 0);
    tick(); #1;
    checkOutput("midrst_wait_valid", valid_insert, 0);
    checkOutput("midrst_wait_busy", busy, 0);
    applyStimulus(0, 4'hF, 0, 0, 0, 0);
    #1;
    checkOutput("midrst_wait_regrant", req_ready, 4'b0001);
    tick(); #1;
    checkOutput("midrst_offer_grant", grant_id, 0);
    applyStimulus(1, 4'hF, 0, 0, 0, 0);
    tick(); #1;
    checkOutput("midrst_offer_valid", valid_insert, 0);
    checkOutput("midrst_offer_busy", busy, 0);
    applyStimulus(0, 4'hF, 0, 0, 0, 0);
    #1;
    checkOutput("midrst_offer_regrant", req_ready, 4'b0001);
    tick();
    applyStimulus(0, 4'h0, 1, 0, 0, 0);
    tick();
    applyStimulus(0, 4'h0, 0, 1, 1, 1);
    tick();

    applyStimulus(0, 4'b0010, 0, 0, 0, 0);
    tick();
    applyStimulus(0, 4'h0, 1, 0, 0, 0);
    tick();
`ifdef HDR_TIMEOUT_EN
    for (int i = 1; i < TO; i++) begin
      applyStimulus(0, 4'h0, 0, 0, 0, 0);
      tick(); #1;
      checkOutput("to_not_yet", timeout, 0);
      checkOutput("to_still_busy", busy, 1);
    end
    tick(); #1;
    checkOutput("to_pulse", timeout, 1);
    checkOutput("to_idle", busy, 0);
    tick(); #1;
    checkOutput("to_pulse_end", timeout, 0);
    applyStimulus(0, 4'b0010, 0, 0, 0, 0);
    tick();
    applyStimulus(0, 4'h0, 1, 0, 0, 0);
    tick();
    for (int i = 1; i < TO; i++) begin
      applyStimulus(0, 4'h0, 0, 0, 0, 0);
      tick();
    end
    applyStimulus(0, 4'h0, 0, 1, 1, 1);
    tick(); #1;
    checkOutput("to_eop_wins", timeout, 0);
    checkOutput("to_eop_idle", busy, 0);
`else
    for (int i = 0; i < 20; i++) begin
      applyStimulus(0, 4'h0, 0, 1, 0, 1);
      tick(); #1;
      checkOutput("noto_still_busy", busy, 1);
    end
    applyStimulus(0, 4'h0, 0, 1, 1, 1);
    tick(); #1;
    checkOutput("noto_eop_idle", busy, 0);
`endif

    for (int c = 0; c < 3000; c++) begin
      applyStimulus($urandom_range(0, 99) == 0, N'($urandom), 1'($urandom),
                    1'($urandom), 1'($urandom), $urandom_range(0, 3) == 0);
      tick();
    end

    applyStimulus(0, 4'h0, 0, 0, 0, 0);
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
